// File: rtl/amba_ahb_pkg.sv
// Shared AHB-Lite encodings, slave FSM states and the byte-lane strobe helper
// for the parametrised memory slave.
package amba_ahb_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'b00,
    TransBusy   = 2'b01,
    TransNonseq = 2'b10,
    TransSeq    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    SizeByte  = 3'b000,
    SizeHalf  = 3'b001,
    SizeWord  = 3'b010,
    SizeDword = 3'b011,
    Size16B   = 3'b100,
    Size32B   = 3'b101,
    Size64B   = 3'b110,
    Size128B  = 3'b111
  } hsize_e;

  localparam logic HrespOkay  = 1'b0;
  localparam logic HrespError = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StErr1,
    StErr2
  } slave_state_e;

  // Little-endian byte-lane enables for one beat; bit i enables byte lane i.
  // Lanes beyond the bus width are always returned as zero.
  function automatic logic [7:0] strb(input hsize_e      hsize,
                                      input logic [2:0]  addr_lsbs,
                                      input int unsigned data_width);
    logic [7:0] size_mask;
    logic [7:0] bus_mask;
    logic [2:0] lsb;
    case (hsize)
      SizeByte: size_mask = 8'h01;
      SizeHalf: size_mask = 8'h03;
      SizeWord: size_mask = 8'h0F;
      default:  size_mask = 8'hFF;
    endcase
    bus_mask = (data_width == 64) ? 8'hFF : 8'h0F;
    lsb      = (data_width == 64) ? addr_lsbs : {1'b0, addr_lsbs[1:0]};
    return (size_mask << lsb) & bus_mask;
  endfunction

endpackage

// File: rtl/ahb_sram_bank.sv
// DEPTH x DATA_WIDTH storage array with per-byte write enables and an
// asynchronous read port. Contents are never reset.
module ahb_sram_bank #(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned NumBytes  = DATA_WIDTH / 8,
  localparam int unsigned AddrW     = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic [NumBytes-1:0]   we_i,
  input  logic [AddrW-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AddrW-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NumBytes; b++) begin
      if (we_i[b]) begin
        mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/amba_ahb_slave_mem_p.sv
// Parametrised AHB-Lite memory slave: configurable width, depth and wait states,
// byte/halfword/word lanes, and a two-cycle ERROR response for bad transfers.
module amba_ahb_slave_mem_p
  import amba_ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  hclk_i,
  input  logic                  hreset_i,
  input  logic                  hsel_i,
  input  logic [ADDR_WIDTH-1:0] haddr_i,
  input  logic [1:0]            htrans_i,
  input  logic                  hwrite_i,
  input  logic [2:0]            hsize_i,
  input  logic [2:0]            hburst_i,
  input  logic [3:0]            hprot_i,
  input  logic [DATA_WIDTH-1:0] hwdata_i,
  output logic [DATA_WIDTH-1:0] hrdata_o,
  output logic                  hready_o,
  output logic                  hresp_o,
  output logic                  error_o
);

  localparam int unsigned NumBytes  = DATA_WIDTH / 8;
  localparam int unsigned LaneW     = $clog2(NumBytes);
  localparam int unsigned WordAw    = $clog2(DEPTH);
  localparam logic [63:0] ByteRange = 64'(DEPTH) * 64'(NumBytes);
  localparam logic [2:0]  MaxSize   = 3'(LaneW);
  localparam logic [3:0]  WaitInit  = 4'(WAIT_STATES);

  slave_state_e state_q, state_d;
  logic [3:0]   wait_cnt_q, wait_cnt_d;

  logic                ph_valid_q, ph_valid_d;
  logic                ph_write_q, ph_write_d;
  logic [WordAw-1:0]   ph_word_q, ph_word_d;
  logic [NumBytes-1:0] ph_strb_q, ph_strb_d;

  htrans_e               trans;
  logic                  accept;
  logic                  addr_err;
  logic [7:0]            align_mask;
  logic [7:0]            lane_all;
  logic                  data_done;
  logic [NumBytes-1:0]   bank_we;
  logic [DATA_WIDTH-1:0] bank_rdata;

  assign trans  = htrans_e'(htrans_i);
  assign accept = hsel_i && hready_o && (trans == TransNonseq || trans == TransSeq);

  // Verdict is taken from the address phase so the bank is never touched on error.
  always_comb begin
    align_mask = 8'((9'd1 << hsize_i) - 9'd1);
    addr_err   = (64'(haddr_i) >= ByteRange) || (hsize_i > MaxSize) ||
                 ((8'(haddr_i) & align_mask) != 8'd0);
    lane_all   = strb(hsize_e'(hsize_i), haddr_i[2:0], DATA_WIDTH);
  end

  // FSM state register.
  always_ff @(posedge hclk_i) begin
    if (hreset_i) begin
      state_q    <= StIdle;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StIdle, StErr2: begin
        state_d = StIdle;
        if (accept) begin
          if (addr_err) begin
            state_d = StErr1;
          end else if (WAIT_STATES != 0) begin
            state_d    = StWait;
            wait_cnt_d = WaitInit;
          end
        end
      end
      StWait: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q == 4'd1) begin
          state_d = StIdle;
        end
      end
      StErr1:  state_d = StErr2;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs. A pending phase seen in StIdle is always its completing cycle.
  always_comb begin
    hready_o  = 1'b1;
    hresp_o   = HrespOkay;
    error_o   = 1'b0;
    data_done = 1'b0;
    unique case (state_q)
      StIdle: data_done = ph_valid_q;
      StWait: hready_o  = 1'b0;
      StErr1: begin
        hready_o = 1'b0;
        hresp_o  = HrespError;
      end
      StErr2: begin
        hresp_o = HrespError;
        error_o = 1'b1;
      end
      default: hready_o = 1'b1;
    endcase
    hrdata_o = (data_done && !ph_write_q) ? bank_rdata : '0;
  end

  // Data-phase register.
  always_comb begin
    ph_valid_d = ph_valid_q;
    ph_write_d = ph_write_q;
    ph_word_d  = ph_word_q;
    ph_strb_d  = ph_strb_q;
    if (accept) begin
      ph_valid_d = 1'b1;
      ph_write_d = hwrite_i;
      ph_word_d  = haddr_i[LaneW +: WordAw];
      ph_strb_d  = lane_all[NumBytes-1:0];
    end else if (hready_o) begin
      ph_valid_d = 1'b0;
    end
  end

  always_ff @(posedge hclk_i) begin
    if (hreset_i) begin
      ph_valid_q <= 1'b0;
      ph_write_q <= 1'b0;
      ph_word_q  <= '0;
      ph_strb_q  <= '0;
    end else begin
      ph_valid_q <= ph_valid_d;
      ph_write_q <= ph_write_d;
      ph_word_q  <= ph_word_d;
      ph_strb_q  <= ph_strb_d;
    end
  end

  // A reset on the completing edge abandons the write.
  assign bank_we = (data_done && ph_write_q && !hreset_i) ? ph_strb_q : '0;

  ahb_sram_bank #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bank (
    .clk_i   (hclk_i),
    .we_i    (bank_we),
    .waddr_i (ph_word_q),
    .wdata_i (hwdata_i),
    .raddr_i (ph_word_q),
    .rdata_o (bank_rdata)
  );

  logic unused_inputs;
  assign unused_inputs = ^{hburst_i, hprot_i, lane_all};

endmodule

// File: tb/tb_amba_ahb_slave_mem_p.sv
// Bench for amba_ahb_slave_mem_p: a zero-wait and a three-wait instance share one
// master; directed scenarios plus randomized traffic against a byte-array model.
module tb_amba_ahb_slave_mem_p;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel, sel_w, hwrite;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;

  logic        hsel0, hselw;
  logic [31:0] rdata0, rdataw;
  logic        ready0, readyw, resp0, respw, err0, errw;
  logic [31:0] obs_rdata;
  logic        obs_ready, obs_resp, obs_err;

  int passed = 0;
  int total  = 0;

  logic [7:0] mem0 [1024];

  always #5 hclk = ~hclk;

  assign hsel0     = hsel & ~sel_w;
  assign hselw     = hsel & sel_w;
  assign obs_rdata = sel_w ? rdataw : rdata0;
  assign obs_ready = sel_w ? readyw : ready0;
  assign obs_resp  = sel_w ? respw : resp0;
  assign obs_err   = sel_w ? errw : err0;

  amba_ahb_slave_mem_p #(
    .ADDR_WIDTH (32), .DATA_WIDTH (32), .DEPTH (256), .WAIT_STATES (0)
  ) u_dut0 (
    .hclk_i (hclk), .hreset_i (hreset), .hsel_i (hsel0), .haddr_i (haddr),
    .htrans_i (htrans), .hwrite_i (hwrite), .hsize_i (hsize), .hburst_i (hburst),
    .hprot_i (hprot), .hwdata_i (hwdata), .hrdata_o (rdata0), .hready_o (ready0),
    .hresp_o (resp0), .error_o (err0)
  );

  amba_ahb_slave_mem_p #(
    .ADDR_WIDTH (32), .DATA_WIDTH (32), .DEPTH (256), .WAIT_STATES (3)
  ) u_dutw (
    .hclk_i (hclk), .hreset_i (hreset), .hsel_i (hselw), .haddr_i (haddr),
    .htrans_i (htrans), .hwrite_i (hwrite), .hsize_i (hsize), .hburst_i (hburst),
    .hprot_i (hprot), .hwdata_i (hwdata), .hrdata_o (rdataw), .hready_o (readyw),
    .hresp_o (respw), .error_o (errw)
  );

  // One non-pipelined transfer; returns what the data phase looked like.
  task automatic xfer(input bit w, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wd, output logic [31:0] rd, output int lows,
                      output logic low_resp, output logic fin_resp, output logic fin_err);
    bit to;
    @(posedge hclk); #1;
    hsel = 1'b1; haddr = addr; htrans = 2'b10; hwrite = w; hsize = size; hburst = 3'b000;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;
    lows = 0; low_resp = 1'b0; to = 1'b0;
    while (!obs_ready && !to) begin
      lows++;
      low_resp = obs_resp;
      @(posedge hclk); #1;
      if (lows > 40) to = 1'b1;
    end
    rd = obs_rdata; fin_resp = obs_resp; fin_err = obs_err;
    total++;
    if (to) $display("FAIL xfer_timeout addr=%h: hready still low after %0d cycles, need high",
                     addr, lows);
    else passed++;
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    repeat (2) @(posedge hclk);
    #1;
    total++;
    if ({ready0, resp0, err0, rdata0} !== {1'b1, 1'b0, 1'b0, 32'h0})
      $display("FAIL reset_dut0: got rdy=%b resp=%b err=%b rd=%h, need 1 0 0 0",
               ready0, resp0, err0, rdata0);
    else passed++;
    total++;
    if ({readyw, respw, errw, rdataw} !== {1'b1, 1'b0, 1'b0, 32'h0})
      $display("FAIL reset_dutw: got rdy=%b resp=%b err=%b rd=%h, need 1 0 0 0",
               readyw, respw, errw, rdataw);
    else passed++;
    hreset = 1'b0;
  endtask

  task automatic test_word_rw();
    logic [31:0] rd; int lows; logic lr, fr, fe;
    sel_w = 1'b0;
    xfer(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, rd, lows, lr, fr, fe);
    total++;
    if (lows !== 0 || fr !== 1'b0) $display("FAIL word_write: lows=%0d resp=%b, need 0 0", lows, fr);
    else passed++;
    xfer(1'b0, 32'h10, 3'd2, 32'h0, rd, lows, lr, fr, fe);
    total++;
    if (lows !== 0 || fr !== 1'b0 || rd !== 32'hDEADBEEF)
      $display("FAIL word_read: lows=%0d resp=%b rd=%h, need 0 0 deadbeef", lows, fr, rd);
    else passed++;
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; int lows; logic lr, fr, fe;
    sel_w = 1'b0;
    xfer(1'b1, 32'h20, 3'd2, 32'h0, rd, lows, lr, fr, fe);
    xfer(1'b1, 32'h21, 3'd0, 32'h0000AA00, rd, lows, lr, fr, fe);
    xfer(1'b0, 32'h20, 3'd2, 32'h0, rd, lows, lr, fr, fe);
    total++;
    if (rd !== 32'h0000AA00) $display("FAIL byte_lane: rd=%h, need 0000aa00", rd);
    else passed++;
    xfer(1'b1, 32'h22, 3'd1, 32'h1234FFFF, rd, lows, lr, fr, fe);
    xfer(1'b0, 32'h20, 3'd2, 32'h0, rd, lows, lr, fr, fe);
    total++;
    if (rd !== 32'h1234AA00) $display("FAIL half_lane: rd=%h, need 1234aa00", rd);
    else passed++;
  endtask

  task automatic test_errors();
    logic [31:0] rd; int lows; logic lr, fr, fe;
    sel_w = 1'b0;
    xfer(1'b1, 32'h0, 3'd2, 32'h11223344, rd, lows, lr, fr, fe);
    xfer(1'b1, 32'h400, 3'd2, 32'hFFFFFFFF, rd, lows, lr, fr, fe);
    total++;
    if (lows !== 1 || lr !== 1'b1 || fr !== 1'b1 || fe !== 1'b1)
      $display("FAIL err_range: lows=%0d r1=%b r2=%b err=%b, need 1 1 1 1", lows, lr, fr, fe);
    else passed++;
    xfer(1'b1, 32'h3, 3'd1, 32'hFFFFFFFF, rd, lows, lr, fr, fe);
    total++;
    if (lows !== 1 || lr !== 1'b1 || fr !== 1'b1 || fe !== 1'b1)
      $display("FAIL err_align: lows=%0d r1=%b r2=%b err=%b, need 1 1 1 1", lows, lr, fr, fe);
    else passed++;
    xfer(1'b1, 32'h8, 3'd3, 32'hFFFFFFFF, rd, lows, lr, fr, fe);
    total++;
    if (lows !== 1 || lr !== 1'b1 || fr !== 1'b1 || fe !== 1'b1)
      $display("FAIL err_size: lows=%0d r1=%b r2=%b err=%b, need 1 1 1 1", lows, lr, fr, fe);
    else passed++;
    xfer(1'b0, 32'h0, 3'd2, 32'h0, rd, lows, lr, fr, fe);
    total++;
    if (rd !== 32'h11223344 || fr !== 1'b0)
      $display("FAIL err_no_write: rd=%h resp=%b, need 11223344 0", rd, fr);
    else passed++;
    xfer(1'b1, 32'h3FF, 3'd0, 32'h5A000000, rd, lows, lr, fr, fe);
    xfer(1'b0, 32'h3FC, 3'd2, 32'h0, rd, lows, lr, fr, fe);
    total++;
    if (rd[31:24] !== 8'h5A || fr !== 1'b0 || lows !== 0)
      $display("FAIL last_byte: rd=%h resp=%b lows=%0d, need 5a...... 0 0", rd, fr, lows);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int highs; logic [31:0] rd;
    sel_w = 1'b0; highs = 0; rd = 32'h0;
    @(posedge hclk); #1;
    hsel = 1'b1; haddr = 32'h40; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    hburst = 3'b011; hprot = 4'($urandom_range(0, 15));
    for (int i = 0; i < 5; i++) begin
      @(posedge hclk); #1;
      if (obs_ready) highs++;
      if (i < 4) hwdata = 32'(i + 1);
      if (i < 3) begin
        haddr = 32'h44 + 32'(4 * i); htrans = 2'b11;
      end else if (i == 3) begin
        haddr = 32'h44; hwrite = 1'b0; htrans = 2'b10; hburst = 3'b000;
      end else begin
        hsel = 1'b0; htrans = 2'b00; rd = obs_rdata;
      end
    end
    total++;
    if (highs !== 5) $display("FAIL burst_ready: high cycles=%0d, need 5", highs);
    else passed++;
    total++;
    if (rd !== 32'd2) $display("FAIL burst_read: rd=%h, need 00000002", rd);
    else passed++;
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; int lows; logic lr, fr, fe;
    sel_w = 1'b1;
    xfer(1'b1, 32'h08, 3'd2, 32'hCAFEF00D, rd, lows, lr, fr, fe);
    total++;
    if (lows !== 3 || fr !== 1'b0) $display("FAIL wait_write: lows=%0d resp=%b, need 3 0", lows, fr);
    else passed++;
    xfer(1'b1, 32'h30, 3'd2, 32'hA5A51234, rd, lows, lr, fr, fe);
    xfer(1'b0, 32'h30, 3'd2, 32'h0, rd, lows, lr, fr, fe);
    total++;
    if (lows !== 3 || rd !== 32'hA5A51234)
      $display("FAIL wait_read: lows=%0d rd=%h, need 3 a5a51234", lows, rd);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int lows; logic lr, fr, fe;
    sel_w = 1'b1;
    @(posedge hclk); #1;
    hsel = 1'b1; haddr = 32'h08; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h12345678;
    @(posedge hclk); #1;
    hreset = 1'b1;
    @(posedge hclk); #1;
    total++;
    if (readyw !== 1'b1 || respw !== 1'b0 || rdataw !== 32'h0)
      $display("FAIL reset_mid_out: rdy=%b resp=%b rd=%h, need 1 0 0", readyw, respw, rdataw);
    else passed++;
    hreset = 1'b0;
    xfer(1'b0, 32'h08, 3'd2, 32'h0, rd, lows, lr, fr, fe);
    total++;
    if (rd !== 32'hCAFEF00D) $display("FAIL reset_mid_mem: rd=%h, need cafef00d", rd);
    else passed++;
  endtask

  task automatic test_random();
    logic [31:0] rd, wd, addr, exp; int lows, a; logic lr, fr, fe;
    logic [2:0] size; bit w, exp_err;
    sel_w = 1'b0;
    for (int i = 0; i < 64; i++) begin
      wd = $urandom;
      xfer(1'b1, 32'(i * 4), 3'd2, wd, rd, lows, lr, fr, fe);
      for (int b = 0; b < 4; b++) mem0[i*4+b] = wd[8*b +: 8];
    end
    for (int n = 0; n < 60; n++) begin
      w    = 1'($urandom_range(0, 1));
      size = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) addr = 32'h400 + 32'($urandom_range(0, 4095));
      else begin
        addr = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
      end
      wd = $urandom;
      exp_err = (addr >= 32'd1024) || (size > 3'd2) || ((addr % (32'd1 << size)) != 0);
      xfer(w, addr, size, wd, rd, lows, lr, fr, fe);
      total++;
      if (exp_err && (lows !== 1 || lr !== 1'b1 || fr !== 1'b1 || fe !== 1'b1))
        $display("FAIL rand_err addr=%h size=%0d: lows=%0d r1=%b r2=%b err=%b, need 1 1 1 1",
                 addr, size, lows, lr, fr, fe);
      else if (!exp_err && (lows !== 0 || fr !== 1'b0 || fe !== 1'b0))
        $display("FAIL rand_okay addr=%h size=%0d: lows=%0d resp=%b err=%b, need 0 0 0",
                 addr, size, lows, fr, fe);
      else passed++;
      if (!exp_err && w) begin
        for (int b = 0; b < (1 << size); b++) begin
          a = int'(addr) + b;
          mem0[a] = wd[8*(a%4) +: 8];
        end
      end
      if (!exp_err && !w) begin
        a   = int'(addr) & ~3;
        exp = {mem0[a+3], mem0[a+2], mem0[a+1], mem0[a]};
        total++;
        if (rd !== exp) $display("FAIL rand_read addr=%h: rd=%h, need %h", addr, rd, exp);
        else passed++;
      end
    end
  endtask

  initial begin
    hreset = 1'b1; hsel = 1'b0; sel_w = 1'b0; hwrite = 1'b0; haddr = 32'h0; hwdata = 32'h0;
    htrans = 2'b00; hsize = 3'd2; hburst = 3'b000; hprot = 4'h0;
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_errors();
    test_back_to_back();
    test_wait_states();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
